// File: rtl/mcycle_ctrl_pkg.sv
// mcycle_ctrl_pkg
// Shared definitions for the 8085-class machine-cycle sequencer and the
// register/ALU block: bus-enable bit indices, decoded-instruction field
// indices, T-state encodings and sequencer mode encodings.
// Optional feature macro used by the sequencer: MCTRL_WAIT_EN.
package mcycle_ctrl_pkg;

  // ienb bit indices
  localparam int IENB_RRD = 0;
  localparam int IENB_RWR = 1;
  localparam int IENB_COD = 2;
  localparam int IENB_DAT = 3;
  localparam int IENB_PC  = 4;
  localparam int IENB_PD  = 5;

  // chk_i field indices
  localparam int INST_GO6    = 0;
  localparam int INST_HLT    = 2;
  localparam int INST_DIO    = 3;
  localparam int INST_CYC_LO = 4;
  localparam int INST_WR_LO  = 8;
  localparam int INST_DP_LO  = 12;
  localparam int INST_COND   = 16;
  localparam int INFO_CYC_W  = 4;

  // T-state encodings
  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T1     = 3'd1;
  localparam logic [2:0] T2     = 3'd2;
  localparam logic [2:0] T3     = 3'd3;
  localparam logic [2:0] T4     = 3'd4;
  localparam logic [2:0] T5     = 3'd5;
  localparam logic [2:0] T6     = 3'd6;
  localparam logic [2:0] T_W    = 3'd7;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_HALT = 2'd2
  } mode_e;

endpackage

// File: rtl/mcycle_ctrl_tstate_cnt.sv
// tstate_cnt
// T-state counter for the machine-cycle sequencer. Advances T1 -> T2 -> ...
// and wraps to T1 when the current state is the terminal state of its
// M-cycle. With MCTRL_WAIT_EN defined, ready is sampled at the end of T2
// and wait states (TW) are inserted until it is high.
// Ports:
//   clk, rst_  clock, asynchronous active-low reset
//   start      load T1 (leaving idle)
//   clr        force T_NONE (entering halt)
//   adv        advance to tst_nxt this clock
//   term       current T-state is the last one of the M-cycle
//   ready      external bus ready (used only with MCTRL_WAIT_EN)
//   tst        registered T-state
//   tst_nxt    value tst takes on the next advancing clock
module tstate_cnt
  import mcycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_,
  input  logic       start,
  input  logic       clr,
  input  logic       adv,
  input  logic       term,
  input  logic       ready,
  output logic [2:0] tst,
  output logic [2:0] tst_nxt
);

`ifdef MCTRL_WAIT_EN
  always_comb begin
    tst_nxt = tst + 3'd1;
    if (term)
      tst_nxt = T1;
    else if (tst == T2 || tst == T_W)
      tst_nxt = ready ? T3 : T_W;
  end
`else
  logic unused_ready;
  assign unused_ready = ready;

  always_comb begin
    tst_nxt = tst + 3'd1;
    if (term)
      tst_nxt = T1;
  end
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      tst <= T_NONE;
    else if (clr)
      tst <= T_NONE;
    else if (start)
      tst <= T1;
    else if (adv)
      tst <= tst_nxt;
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl
// Machine-cycle / T-state sequencer for the 8085-class core. Walks M1 and
// the extra M2..M5 cycles selected by the decoded instruction, drives the
// datapath bus-enable vector and the external bus strobes.
// Optional feature macro: MCTRL_WAIT_EN (wait-state insertion on ready).
// Ports:
//   clk     core clock
//   rst_    asynchronous active-low reset
//   chk_i   decoded instruction info (valid from M1/T4 to end of instruction)
//   ready   external bus ready
//   ienb    bus enables {PD_, PC_, DAT, COD, RWR, RRD}
//   ale     address latch enable
//   rd_     read strobe, active low
//   wr_     write strobe, active low
//   io_m    I/O cycle
//   halted  core in HALT
//   mcyc    current M-cycle (0 = idle)
//   tst     current T-state (7 = wait)
//
// mode      | meaning
// ----------+-----------------------------------------------
// MODE_IDLE | in/just out of reset, all outputs inactive
// MODE_RUN  | sequencing M-cycles; mcyc/tst give position
// MODE_HALT | HLT executed, outputs inactive until reset
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
#(
  parameter int INSTSIZE = 17,
  parameter int IENBSIZE = 6,
  parameter int INFO_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [INSTSIZE-1:0] chk_i,
  input  logic                ready,
  output logic [IENBSIZE-1:0] ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                io_m,
  output logic                halted,
  output logic [2:0]          mcyc,
  output logic [2:0]          tst
);

  mode_e               mode;
  mode_e               mode_nxt;
  logic [2:0]          mcyc_nxt;
  logic [2:0]          tst_nxt;
  logic                go6;
  logic                hlt;
  logic                dio;
  logic [INFO_CYC-1:0] cyc_mask;
  logic [INFO_CYC-1:0] wr_mask;
  logic [INFO_CYC-1:0] dp_mask;
  logic [INFO_CYC:0]   mask_ext;
  logic [1:0]          cyc_idx;
  logic                in_run;
  logic                in_m1;
  logic                term;
  logic                cyc_end;
  logic                last_cyc;
  logic                halt_go;
  logic                cur_wr;
  logic                cur_pd;
  logic                t2_hold;
  logic                unused_chk;

  assign go6      = chk_i[INST_GO6];
  assign hlt      = chk_i[INST_HLT];
  assign dio      = chk_i[INST_DIO];
  assign cyc_mask = chk_i[INST_CYC_LO +: INFO_CYC];
  assign wr_mask  = chk_i[INST_WR_LO +: INFO_CYC];
  assign dp_mask  = chk_i[INST_DP_LO +: INFO_CYC];
  // condition bit is resolved upstream; bit 1 carries nothing for us
  assign unused_chk = ^{chk_i[INST_COND], chk_i[1]};

  assign in_run = (mode == MODE_RUN);
  assign in_m1  = in_run && (mcyc == 3'd1);

  // M2..M5 map to mask bits 0..3; mcyc 5 wraps to index 3
  assign cyc_idx  = mcyc[1:0] - 2'd2;
  assign cur_wr   = wr_mask[cyc_idx];
  assign cur_pd   = dp_mask[cyc_idx];
  // a zero appended above bit 3 makes M5 always the last cycle
  assign mask_ext = {1'b0, cyc_mask};
  assign last_cyc = !mask_ext[3'(cyc_idx) + 3'd1];

  assign term = in_run && (in_m1 ? ((tst == T4 && !go6) || tst == T6)
                                 : (tst == T3));
  assign cyc_end = in_run && (tst_nxt == T1);

  // TW repeats the T2 strobe pattern
  assign t2_hold = (tst == T2) || (tst == T_W);

  tstate_cnt u_tstate_cnt (
    .clk     (clk),
    .rst_    (rst_),
    .start   (mode == MODE_IDLE),
    .clr     (halt_go),
    .adv     (in_run),
    .term    (term),
    .ready   (ready),
    .tst     (tst),
    .tst_nxt (tst_nxt)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mode <= MODE_IDLE;
      mcyc <= 3'd0;
    end else begin
      mode <= mode_nxt;
      mcyc <= mcyc_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode;
    mcyc_nxt = mcyc;
    halt_go  = 1'b0;
    case (mode)
      MODE_IDLE: begin
        mode_nxt = MODE_RUN;
        mcyc_nxt = 3'd1;
      end
      MODE_RUN: begin
        if (in_m1 && tst == T4 && hlt) begin
          mode_nxt = MODE_HALT;
          mcyc_nxt = 3'd0;
          halt_go  = 1'b1;
        end else if (cyc_end) begin
          if (in_m1)
            mcyc_nxt = cyc_mask[0] ? 3'd2 : 3'd1;
          else
            mcyc_nxt = last_cyc ? 3'd1 : mcyc + 3'd1;
        end
      end
      MODE_HALT: begin
        mode_nxt = MODE_HALT;
      end
      default: begin
        mode_nxt = MODE_IDLE;
        mcyc_nxt = 3'd0;
      end
    endcase
  end

  always_comb begin
    ienb   = '0;
    ale    = 1'b0;
    rd_    = 1'b1;
    wr_    = 1'b1;
    io_m   = 1'b0;
    halted = (mode == MODE_HALT);
    if (in_run) begin
      ale = (tst == T1);
      if (in_m1) begin
        rd_ = !(t2_hold || tst == T3);
        if (tst == T3) begin
          ienb[IENB_COD] = 1'b1;
          ienb[IENB_PC]  = 1'b1;
        end
        if (tst == T4 || tst == T6)
          ienb[IENB_RRD] = 1'b1;
        if (tst == T6 || (tst == T4 && cyc_mask == '0 && !go6))
          ienb[IENB_RWR] = 1'b1;
      end else begin
        ienb[IENB_PD] = cur_pd;
        io_m          = last_cyc && dio;
        if (cur_wr) begin
          ienb[IENB_RRD] = 1'b1;
          wr_            = !(t2_hold || tst == T3);
        end else begin
          rd_ = !(t2_hold || tst == T3);
          if (tst == T3) begin
            ienb[IENB_DAT] = 1'b1;
            ienb[IENB_PC]  = !cur_pd;
            ienb[IENB_RWR] = last_cyc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
module tb_mcycle_ctrl;

`ifdef MCTRL_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_;
  logic        ready;
  logic [16:0] chk_i;
  logic [5:0]  ienb;
  logic        ale, rd_, wr_, io_m, halted;
  logic [2:0]  mcyc, tst;

  always #5 clk = ~clk;

  mcycle_ctrl dut (
    .clk    (clk),
    .rst_   (rst_),
    .chk_i  (chk_i),
    .ready  (ready),
    .ienb   (ienb),
    .ale    (ale),
    .rd_    (rd_),
    .wr_    (wr_),
    .io_m   (io_m),
    .halted (halted),
    .mcyc   (mcyc),
    .tst    (tst)
  );

  typedef struct packed {
    logic [2:0] mcyc;
    logic [2:0] tst;
    logic       chk_pos;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
    logic       io_m;
    logic       halted;
    logic [5:0] ienb;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.chk_pos = 1'b1;
    e.rd_n    = 1'b1;
    e.wr_n    = 1'b1;
    return e;
  endfunction

  function automatic exp_t halt_exp();
    exp_t e;
    e = idle_exp();
    e.chk_pos = 1'b0;
    e.halted  = 1'b1;
    return e;
  endfunction

  // number of extra cycles: run of ones from mask bit 0
  function automatic int n_extra(logic [3:0] mask);
    int n;
    n = 0;
    while (n < 4 && mask[n]) n++;
    return n;
  endfunction

  // expected outputs for M-cycle m at T-state t (7 = wait) of instruction c
  function automatic exp_t run_exp(int m, int t, logic [16:0] c);
    exp_t e;
    int   te, k;
    bit   strobe, last, pd, wr;
    e      = idle_exp();
    e.mcyc = 3'(m);
    e.tst  = 3'(t);
    te     = (t == 7) ? 2 : t;
    strobe = (te == 2 || te == 3);
    e.ale  = (t == 1);
    if (m == 1) begin
      e.rd_n    = !strobe;
      e.ienb[2] = (t == 3);
      e.ienb[4] = (t == 3);
      e.ienb[0] = (t == 4 || t == 6);
      e.ienb[1] = (t == 6) || (t == 4 && c[7:4] == 4'd0 && !c[0]);
    end else begin
      k    = m - 2;
      last = ((m - 1) == n_extra(c[7:4]));
      pd   = c[12 + k];
      wr   = c[8 + k];
      e.ienb[5] = pd;
      e.io_m    = last && c[3];
      if (wr) begin
        e.ienb[0] = 1'b1;
        e.wr_n    = !strobe;
      end else begin
        e.rd_n = !strobe;
        if (t == 3) begin
          e.ienb[3] = 1'b1;
          e.ienb[4] = !pd;
          e.ienb[1] = last;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [16:0] mk(bit go6, bit hlt, bit dio,
                                     logic [3:0] mask, logic [3:0] wr,
                                     logic [3:0] dp);
    return {1'($urandom), dp, wr, mask, dio, hlt, 1'($urandom), go6};
  endfunction

  task automatic drive(input exp_t e, input logic [16:0] c, input logic r);
    @(posedge clk);
    #1;
    chk_i = c;
    ready = r;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_ = 1'b0;
    exp_q.push_back(idle_exp());
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    exp_q.push_back(idle_exp());
  endtask

  // w: wait states per M-cycle (<0 = random 0..2, only with wait feature)
  // abort_at: cycle index to reset at, -2 = first wait state, -1 = none
  task automatic run_instr(input logic [16:0] c, input int w, input int abort_at);
    int          ne, cyc, nw, mlast;
    int          tl[$];
    logic        r;
    logic [16:0] cd;
    ne    = n_extra(c[7:4]);
    mlast = c[2] ? 1 : 1 + ne;
    cyc   = 0;
    for (int m = 1; m <= mlast; m++) begin
      tl.delete();
      nw = 0;
      if (WAIT_EN) nw = (w >= 0) ? w : int'($urandom_range(0, 2));
      tl.push_back(1);
      tl.push_back(2);
      repeat (nw) tl.push_back(7);
      tl.push_back(3);
      if (m == 1) begin
        tl.push_back(4);
        if (c[0] && !c[2]) begin
          tl.push_back(5);
          tl.push_back(6);
        end
      end
      for (int i = 0; i < tl.size(); i++) begin
        if (cyc == abort_at || (abort_at == -2 && tl[i] == 7)) begin
          do_reset();
          return;
        end
        if (tl[i] == 2)      r = WAIT_EN ? (nw == 0) : 1'($urandom);
        else if (tl[i] == 7) r = (tl[i+1] != 7);
        else                 r = 1'($urandom);
        cd = (m == 1 && tl[i] < 4) ? 17'($urandom) : c;
        drive(run_exp(m, tl[i], c), cd, r);
        cyc++;
      end
    end
    if (c[2]) begin
      repeat (20) drive(halt_exp(), 17'($urandom), 1'($urandom));
      do_reset();
    end
  endtask

  task automatic random_instr(input int abort_at);
    int         len;
    logic [3:0] mask;
    len  = $urandom_range(0, 4);
    mask = 4'((1 << len) - 1) | (4'($urandom) & ~4'((1 << (len + 1)) - 1));
    run_instr(mk(1'($urandom), 1'b0, 1'($urandom), mask, 4'($urandom),
                 4'($urandom)), -1, abort_at);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: DUT cycle at %0t with no expected entry", $time);
      end else begin
        e  = exp_q.pop_front();
        ok = ({ale, rd_, wr_, io_m, halted, ienb} ===
              {e.ale, e.rd_n, e.wr_n, e.io_m, e.halted, e.ienb});
        if (e.chk_pos)
          ok = ok && ({mcyc, tst} === {e.mcyc, e.tst});
        if (!ok) begin
          errors++;
          $display("FAIL cycle t=%0t: got mcyc=%0d tst=%0d ale=%b rd_=%b wr_=%b io_m=%b halted=%b ienb=%b, want mcyc=%0d tst=%0d ale=%b rd_=%b wr_=%b io_m=%b halted=%b ienb=%b",
                   $time, mcyc, tst, ale, rd_, wr_, io_m, halted, ienb,
                   e.mcyc, e.tst, e.ale, e.rd_n, e.wr_n, e.io_m, e.halted, e.ienb);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_  = 1'b0;
    ready = 1'b1;
    chk_i = '0;
    @(posedge clk);
    #1;
    exp_q.push_back(idle_exp());
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    exp_q.push_back(idle_exp());

    run_instr(mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000), 0, -1);  // MOV B,C
    run_instr(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000), 2, -1);  // MVI A
    run_instr(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001), 0, -1);  // MOV M,A
    run_instr(mk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000), 0, -1);  // INX H
    run_instr(mk(1'b0, 1'b0, 1'b1, 4'b0011, 4'b0010, 4'b0010), 0, -1);  // OUT
    run_instr(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1010, 4'b0110), 0, -1);  // M5 bound
    run_instr(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000), 2, -2);  // reset in TW
    run_instr(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000), 0, -1);

    for (int k = 0; k < 80; k++)
      random_instr((k % 9 == 8) ? int'($urandom_range(0, 8)) : -1);

    run_instr(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000), 0, -1);  // HLT
    run_instr(mk(1'b1, 1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000), -1, -1); // HLT w/ mask
    for (int k = 0; k < 4; k++)
      random_instr(-1);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
Name: mcycle_ctrl

Overview:
- Machine-cycle / T-state sequencer for the 8085-class core.
- Takes the decoded instruction info vector from the ALU/register block and drives its 6-bit bus-enable vector (ienb).
- Generates the external bus strobes (ale, rd_, wr_, io_m) and exposes the current M-cycle/T-state for debug.
- Sits between the core datapath and the external bus interface.

Parameters:
- INSTSIZE, 17, width of decoded instruction info vector
- IENBSIZE, 6, width of bus-enable vector
- INFO_CYC, 4, width of each per-cycle info field (extra M2..M5)

Ports:
- clk  input  1  core clock, all state changes on rising edge
- rst_  input  1  asynchronous, active-low reset
- chk_i  input  17  decoded instruction info. Bits: [0] GO6, [2] HLT, [3] DIO, [7:4] extra-cycle mask, [11:8] write mask, [15:12] data-pointer mask, [16] condition
- ready  input  1  external bus ready (see Optional Feature)
- ienb  output  6  bus enables. Bits: [0] RRD, [1] RWR, [2] COD, [3] DAT, [4] PC_, [5] PD_
- ale  output  1  address latch enable
- rd_  output  1  read strobe, active low
- wr_  output  1  write strobe, active low
- io_m  output  1  1 = I/O cycle
- halted  output  1  core in HALT
- mcyc  output  3  current M-cycle, 1..5; 0 = idle
- tst  output  3  current T-state, 1..6; 7 = wait

Behaviour:
- State: registered {mode (IDLE/RUN/HALT), mcyc, tst}. All outputs are decoded combinationally from state plus chk_i.
- Reset (rst_ low, asynchronous): mode=IDLE, mcyc=0, tst=0.
  - Outputs while reset or IDLE: ienb=0, ale=0, rd_=1, wr_=1, io_m=0, halted=0.
  - First clock edge after rst_ rises: enter RUN at M1/T1.
- M1 (opcode fetch):
  - T1: ale=1, PD_=0.
  - T2: rd_=0.
  - T3: rd_=0, COD=1, PC_=1. The instruction latches at the end of T3.
  - T4: chk_i is valid. RRD=1. If mask[7:4]==0 and GO6=0: RWR=1 and return to M1/T1.
  - GO6=1: continue through T5 (idle) and T6. T6 asserts RRD and RWR, then returns to M1/T1 (or M2/T1 if mask[7:4]!=0).
- Mn, n=2..5, present when mask bit n-2 is set. The mask is contiguous from bit 0; the controller walks bits upward and ends at the first 0.
  - Every Mn: PD_ = data-pointer bit n-2 for the whole cycle. T1: ale=1.
  - Read cycle (write bit n-2 = 0):
    - T2, T3: rd_=0.
    - T3: DAT=1. If PD_=0, also PC_=1 (immediate byte).
    - If this is the last cycle, T3 also asserts RWR.
  - Write cycle (write bit n-2 = 1):
    - T1..T3: RRD=1.
    - T2, T3: wr_=0.
  - io_m=1 for the whole final cycle when DIO=1.
  - After T3 of the last cycle: go to M1/T1.
- HLT=1 at M1/T4: enter HALT regardless of the mask.
  - halted=1, all strobes inactive, ienb=0.
  - Exit only via rst_.
- chk_i[16] is not consumed. Conditional skipping is handled upstream.
- chk_i is treated as stable from M1/T4 to the end of the instruction. The instruction register is written only by COD.
- Reset asserted mid-cycle aborts immediately. No partial strobes after reset is asserted.

Optional Feature:
- Macro: MCTRL_WAIT_EN.
- Defined:
  - ready is sampled at the end of T2 of every M-cycle. If low, the next state is TW (tst=7).
  - TW repeats while ready=0. rd_/wr_/PD_/RRD hold their T2 values. ale=0, no COD/DAT/PC_.
  - ready=1 in TW: proceed to T3.
- Undefined: ready is ignored; T2 always goes to T3.

Decomposition:
- Shared package/include holds:
  - IENB_* bit indices
  - INST_* / INFO_CYC field indices
  - T-state encodings (T1..T6, TW=7)
  - mode encodings
- All are already used by the register/ALU block, so they must not be duplicated.
- One sub-module: tstate_cnt. It holds the T-state counter with wait insertion and a terminal-state input, and returns the next-tst value.

Test Plan:
- MOV B,C (0x41): after reset, M1 T1..T4. COD only at T3. RWR+RRD at T4. Next ale 4 clocks after the first.
- MVI A,0x5A (0x3E, mask 0001, write 0000): M1 + M2 read (7 clocks). PC_ at M1/T3 and M2/T3. DAT+RWR at M2/T3. PD_=0 throughout.
- MOV M,A (0x77, mask 0001, write 0001, dp 0001): M2 has PD_=1 throughout, RRD T1..T3, wr_ low T2..T3, rd_ high, no PC_ in M2.
- INX H (0x23, GO6): 6-clock M1. RWR only at T6. Next ale at clock 7.
- HLT (0x76): halted=1 from the cycle after M1/T4. ienb stays 0 for 20 clocks. rst_ pulse returns to M1/T1.
- MCTRL_WAIT_EN with ready=0 for 2 clocks at M2/T2 of MVI: tst=7 twice, rd_ held low, total 9 clocks. Async reset during a TW forces all outputs inactive in the same cycle.
